// File: rtl/stream_parity_vote_pkg.sv
// Shared types and helpers for the framed parity/majority reducer.
// Word and frame modes, FSM states and a width-bounded popcount.
package stream_parity_vote_pkg;

  typedef enum logic {
    MODE_PARITY   = 1'b0,
    MODE_MAJORITY = 1'b1
  } mode_e;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_ACCUM = 1'b1
  } state_e;

  // Widest word the popcount helper handles; callers zero-extend into it.
  localparam int unsigned POP_MAX_W = 64;

  function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] v,
                                           input int unsigned          w);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < POP_MAX_W; i++) begin
      if (i < w && v[i]) n = n + 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/stream_parity_vote_if.sv
// Word-in / result-out handshake bundle for stream_parity_vote.
// master = producer/consumer side, slave = the reducer.
interface stream_parity_vote_if #(
  parameter int WIDTH     = 5,
  parameter int MAX_FRAME = 16
);
  localparam int CNT_W = $clog2(MAX_FRAME + 1);

  logic             mode_i;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic             out_bit;
  logic [CNT_W-1:0] out_count;
  logic             out_overflow;

  modport master (
    output mode_i, in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_bit, out_count, out_overflow
  );

  modport slave (
    input  mode_i, in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_bit, out_count, out_overflow
  );

endinterface

// File: rtl/stream_parity_vote_word_reduce.sv
// Combinational reduction of one word to a single bit:
// XOR parity, or strict bit-majority (even-width tie gives 0).
module word_reduce
  import stream_parity_vote_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] data,
  input  mode_e            mode,
  output logic             word_bit
);

  localparam int unsigned W_U  = WIDTH;
  localparam int unsigned HALF = WIDTH / 2;

  logic [POP_MAX_W-1:0] data_ext;

  assign data_ext = POP_MAX_W'(data);

  // NOTE: every output of an always_comb gets a default first so no path can infer a latch.
  always_comb begin
    word_bit = ^data;
    if (mode == MODE_MAJORITY) begin
      word_bit = (popcount(data_ext, W_U) > HALF);
    end
  end

endmodule

// File: rtl/stream_parity_vote.sv
// Framed reducer: folds per-word bits into one parity or majority result
// per frame and presents it as a registered valid/ready output.
module stream_parity_vote
  import stream_parity_vote_pkg::*;
#(
  parameter  int WIDTH     = 5,
  parameter  int MAX_FRAME = 16,
  localparam int CNT_W     = $clog2(MAX_FRAME + 1)
) (
  input logic                 clk,
  input logic                 rst_n,
  stream_parity_vote_if.slave bus
);

  state_e           state_q;
  mode_e            mode_q;
  logic             acc_q;
  logic [CNT_W-1:0] ones_q;
  logic [CNT_W-1:0] count_q;
  logic             out_valid_q;
  logic             out_bit_q;
  logic [CNT_W-1:0] out_count_q;
  logic             out_overflow_q;

  logic             accept;
  mode_e            frame_mode;
  logic             word_bit;
  logic             acc_d;
  logic [CNT_W-1:0] ones_d;
  logic [CNT_W-1:0] count_d;
  logic             at_max;
  logic             closing;
  logic             frame_bit_d;
  logic             overflow_d;

  assign bus.in_ready = ~out_valid_q | bus.out_ready;
  assign accept       = bus.in_valid & bus.in_ready;

  // The first beat of a frame uses the live mode; later beats use the latched one.
  assign frame_mode = (state_q == S_IDLE) ? mode_e'(bus.mode_i) : mode_q;

  word_reduce #(.WIDTH(WIDTH)) u_word_reduce (
    .data     (bus.in_data),
    .mode     (frame_mode),
    .word_bit (word_bit)
  );

  always_comb begin
    acc_d       = acc_q ^ word_bit;
    ones_d      = ones_q + CNT_W'(word_bit);
    count_d     = count_q + CNT_W'(1);
    at_max      = (count_d == CNT_W'(MAX_FRAME));
    closing     = accept & (bus.in_last | at_max);
    overflow_d  = at_max & ~bus.in_last;
    frame_bit_d = acc_d;
    if (frame_mode == MODE_MAJORITY) begin
      // One extra bit so doubling ones cannot wrap.
      frame_bit_d = ({ones_d, 1'b0} > {1'b0, count_d});
    end
  end

  // NOTE: all sequential state uses non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      mode_q         <= MODE_PARITY;
      acc_q          <= 1'b0;
      ones_q         <= '0;
      count_q        <= '0;
      out_valid_q    <= 1'b0;
      out_bit_q      <= 1'b0;
      out_count_q    <= '0;
      out_overflow_q <= 1'b0;
    end else begin
      if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (accept) begin
        if (closing) begin
          out_valid_q    <= 1'b1;
          out_bit_q      <= frame_bit_d;
          out_count_q    <= count_d;
          out_overflow_q <= overflow_d;
          state_q        <= S_IDLE;
          acc_q          <= 1'b0;
          ones_q         <= '0;
          count_q        <= '0;
        end else begin
          state_q <= S_ACCUM;
          acc_q   <= acc_d;
          ones_q  <= ones_d;
          count_q <= count_d;
          if (state_q == S_IDLE) begin
            mode_q <= frame_mode;
          end
        end
      end
    end
  end

  assign bus.out_valid    = out_valid_q;
  assign bus.out_bit      = out_bit_q;
  assign bus.out_count    = out_count_q;
  assign bus.out_overflow = out_overflow_q;

endmodule

// File: tb/tb_stream_parity_vote.sv
// Directed bench for stream_parity_vote with WIDTH=5, MAX_FRAME=4:
// a per-cycle vector table plus hand sequences for reset behaviour.
module tb_stream_parity_vote;
  import stream_parity_vote_pkg::*;

  localparam int WIDTH     = 5;
  localparam int MAX_FRAME = 4;

  typedef struct {
    logic             v;
    logic [WIDTH-1:0] d;
    logic             l;
    logic             m;
    logic             ordy;
    logic             e_irdy;
    logic             e_ov;
    logic             e_ob;
    logic [2:0]       e_oc;
    logic             e_oo;
  } vec_t;

  typedef struct {
    logic [WIDTH-1:0] d;
    mode_e            m;
    logic             e;
  } wvec_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  vec_t  vecs[26];
  wvec_t wvecs[5];

  logic [WIDTH-1:0] ref_data;
  mode_e            ref_mode;
  logic             ref_bit;

  stream_parity_vote_if #(.WIDTH(WIDTH), .MAX_FRAME(MAX_FRAME)) bus ();

  stream_parity_vote #(.WIDTH(WIDTH), .MAX_FRAME(MAX_FRAME)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  word_reduce #(.WIDTH(WIDTH)) u_ref (
    .data     (ref_data),
    .mode     (ref_mode),
    .word_bit (ref_bit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic v, input logic [WIDTH-1:0] d, input logic l,
                              input logic m, input logic ordy, input logic e_irdy,
                              input logic e_ov, input logic e_ob, input logic [2:0] e_oc,
                              input logic e_oo);
    vec_t r;
    r.v = v; r.d = d; r.l = l; r.m = m; r.ordy = ordy;
    r.e_irdy = e_irdy; r.e_ov = e_ov; r.e_ob = e_ob; r.e_oc = e_oc; r.e_oo = e_oo;
    return r;
  endfunction

  task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic l,
                       input logic m, input logic ordy);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_last   = l;
    bus.mode_i    = m;
    bus.out_ready = ordy;
  endtask

  task automatic check_out(input string tag, input logic ov, input logic ob,
                           input logic [2:0] oc, input logic oo);
    check({tag, " out_valid"},    32'(bus.out_valid),    32'(ov));
    check({tag, " out_bit"},      32'(bus.out_bit),      32'(ob));
    check({tag, " out_count"},    32'(bus.out_count),    32'(oc));
    check({tag, " out_overflow"}, 32'(bus.out_overflow), 32'(oo));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;

    //            v  data      l  m  ordy | irdy ov ob oc oo
    vecs[0]  = mk(1, 5'b10110, 0, 0, 1,    1,   0, 0, 0, 0); // parity frame
    vecs[1]  = mk(1, 5'b00001, 1, 0, 0,    1,   1, 0, 2, 0);
    vecs[2]  = mk(0, 5'b00000, 0, 0, 1,    1,   0, 0, 2, 0);
    vecs[3]  = mk(1, 5'b11100, 0, 1, 1,    1,   0, 0, 2, 0); // majority frame
    vecs[4]  = mk(1, 5'b00011, 0, 1, 1,    1,   0, 0, 2, 0);
    vecs[5]  = mk(1, 5'b11011, 1, 1, 1,    1,   1, 1, 3, 0);
    vecs[6]  = mk(1, 5'b10000, 0, 0, 1,    1,   0, 1, 3, 0); // overflow frame
    vecs[7]  = mk(1, 5'b11000, 0, 0, 1,    1,   0, 1, 3, 0);
    vecs[8]  = mk(1, 5'b10101, 0, 0, 1,    1,   0, 1, 3, 0);
    vecs[9]  = mk(1, 5'b00100, 0, 0, 1,    1,   1, 1, 4, 1);
    vecs[10] = mk(1, 5'b00010, 1, 0, 1,    1,   1, 1, 1, 0); // 5th word: new frame
    vecs[11] = mk(1, 5'b11111, 0, 1, 1,    1,   0, 1, 1, 0); // last on MAX_FRAME, tie
    vecs[12] = mk(1, 5'b11111, 0, 1, 1,    1,   0, 1, 1, 0);
    vecs[13] = mk(1, 5'b00000, 0, 1, 1,    1,   0, 1, 1, 0);
    vecs[14] = mk(1, 5'b00001, 1, 1, 1,    1,   1, 0, 4, 0);
    vecs[15] = mk(1, 5'b00000, 0, 0, 0,    0,   1, 0, 4, 0); // backpressure
    vecs[16] = mk(1, 5'b00000, 0, 0, 0,    0,   1, 0, 4, 0);
    vecs[17] = mk(1, 5'b00000, 0, 0, 0,    0,   1, 0, 4, 0);
    vecs[18] = mk(1, 5'b00111, 1, 1, 1,    1,   1, 1, 1, 0); // reload on handshake
    vecs[19] = mk(0, 5'b00000, 0, 0, 1,    1,   0, 1, 1, 0);
    vecs[20] = mk(1, 5'b11100, 0, 0, 1,    1,   0, 1, 1, 0); // mode latched = parity
    vecs[21] = mk(1, 5'b11110, 0, 1, 1,    1,   0, 1, 1, 0);
    vecs[22] = mk(1, 5'b10000, 1, 1, 1,    1,   1, 0, 3, 0);
    vecs[23] = mk(1, 5'b11100, 0, 1, 1,    1,   0, 0, 3, 0); // mode latched = majority
    vecs[24] = mk(1, 5'b11110, 0, 0, 1,    1,   0, 0, 3, 0);
    vecs[25] = mk(1, 5'b10000, 1, 0, 1,    1,   1, 1, 3, 0);

    wvecs[0] = '{5'b10110, MODE_PARITY,   1'b1};
    wvecs[1] = '{5'b00011, MODE_MAJORITY, 1'b0};
    wvecs[2] = '{5'b00111, MODE_MAJORITY, 1'b1};
    wvecs[3] = '{5'b11111, MODE_PARITY,   1'b1};
    wvecs[4] = '{5'b00000, MODE_MAJORITY, 1'b0};

    for (int i = 0; i < 5; i++) begin
      ref_data = wvecs[i].d;
      ref_mode = wvecs[i].m;
      #1;
      check($sformatf("word_reduce[%0d]", i), 32'(ref_bit), 32'(wvecs[i].e));
    end

    rst_n = 1'b0;
    drive(0, '0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check_out("reset", 0, 0, 0, 0);
    check("reset in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 26; i++) begin
      drive(vecs[i].v, vecs[i].d, vecs[i].l, vecs[i].m, vecs[i].ordy);
      #2;
      check($sformatf("v%0d in_ready", i), 32'(bus.in_ready), 32'(vecs[i].e_irdy));
      @(posedge clk);
      #1;
      check_out($sformatf("v%0d", i), vecs[i].e_ov, vecs[i].e_ob, vecs[i].e_oc, vecs[i].e_oo);
    end

    // Mid-frame reset: two words accepted (the first also drains the pending result).
    drive(1, 5'b11111, 0, 0, 1);
    @(posedge clk);
    #1;
    drive(1, 5'b00000, 0, 0, 1);
    @(posedge clk);
    #1;
    check("midframe state", 32'(dut.state_q), 32'(S_ACCUM));
    drive(0, '0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    check_out("midreset", 0, 0, 0, 0);
    check("midreset in_ready", 32'(bus.in_ready), 32'd1);
    check("midreset state", 32'(dut.state_q), 32'(S_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive(1, 5'b00111, 1, 1, 0);
    @(posedge clk);
    #1;
    check_out("after reset frame", 1, 1, 1, 0);
    drive(0, '0, 0, 0, 1);
    @(posedge clk);
    #1;
    check("drain out_valid", 32'(bus.out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
